mac_feeder_2x2: RTL and testbench
=================================

Name: mac_feeder_2x2

Overview:
Operand feeder that sits directly upstream of the 2x2 MAC array (mac_4x4). It buffers a 2xK A matrix and a Kx2 B matrix written by a host/DMA port. On start it streams them into the array's in_a0/in_a1/in_b0/in_b1 inputs with the diagonal (systolic) skew. It pulses a clear before streaming, waits a drain window, then signals done so the array outputs o00..o11 can be read.

Parameters:
DW, 32, operand width; matches array in_* width.
K, 4, inner (reduction) dimension, i.e. words per A row / B column; K >= 1.
DRAIN, 3, idle cycles after last operand before done, covering array propagation.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
wr_en  in  1  buffer write strobe.
wr_sel  in  1  0 = write A buffer, 1 = write B buffer.
wr_lane  in  1  A: row index; B: column index.
wr_k  in  $clog2(K) (min 1)  element index along K.
wr_data  in  DW  element value.
start  in  1  begin a stream; sampled only in IDLE.
busy  out  1  high while a stream is in progress.
done  out  1  one-cycle pulse at end of drain.
mac_clr  out  1  one-cycle clear for the array accumulators.
in_a0, in_a1  out  DW  A-row operands to array.
in_b0, in_b1  out  DW  B-column operands to array.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0; busy, done, mac_clr = 0; all in_* = 0. Buffer contents are not reset; they are undefined until written.
- Buffers: abuf[2][K] and bbuf[2][K] registers. Writes take effect on the edge where wr_en=1, only in IDLE. Writes are ignored when busy=1 or when wr_k >= K.
- FSM states: IDLE -> CLEAR -> STREAM -> DRAIN -> DONE -> IDLE. All outputs are registered.
- IDLE: start=1 -> CLEAR. start is ignored in every other state; there is no queueing.
- CLEAR: lasts 1 cycle. mac_clr=1 and busy=1. Counter t cleared to 0.
- STREAM: lasts K+1 cycles, t = 0..K.
  - in_a0 = abuf[0][t] if t<K, else 0.
  - in_a1 = abuf[1][t-1] if 1<=t<=K, else 0.
  - in_b0 = bbuf[0][t] if t<K, else 0.
  - in_b1 = bbuf[1][t-1] if 1<=t<=K, else 0.
  - The values for count t are visible on the outputs during STREAM cycle t.
- DRAIN: lasts DRAIN cycles. All in_* = 0.
- DONE: lasts 1 cycle. done=1 and busy=1, then return to IDLE with busy=0.
- busy timing: high from the first CLEAR cycle through the DONE cycle inclusive. Total busy duration is K+DRAIN+3 cycles.
- start and wr_en together in IDLE: the write is applied and the stream uses the newly written value.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Buffer contents are retained.
- No arithmetic is performed; data passes through unmodified.
- Counter width is $clog2(K+1); it must not wrap at t=K.

Decomposition:
- Shared package (mac_pkg): DW default, FSM state encoding (IDLE, CLEAR, STREAM, DRAIN, DONE), and the function deriving skewed index validity.
- One natural sub-module: mac_operand_buf, a 2xK register file with one write port and two combinational read ports at indices t and t-1. It is instantiated once for A and once for B.

Test Plan:
- Reset values: hold rst=0 for 2 cycles -> busy=done=mac_clr=0 and all in_*=0. Assert rst mid-cycle -> outputs clear without waiting for a clock edge.
- Basic skew, K=4, DRAIN=3. Load A rows {1,2,3,4},{5,6,7,8}; B cols {1,1,1,1},{2,0,1,0}; pulse start.
  - Next cycle: mac_clr=1.
  - STREAM (a0,a1,b0,b1) sequence: (1,0,1,0), (2,5,1,2), (3,6,1,0), (4,7,1,1), (0,8,0,0).
  - Then 3 zero cycles, then done=1. busy is high for exactly 10 cycles.
- Integration with mac_4x4 driven from the feeder using the same data -> after done: o00=10, o01=5, o10=26, o11=17.
- Busy lockout: during STREAM issue start=1 and write A[0][0]=99 -> no restart; done appears once. A second run reproduces the same sequence with a0 first value 1.
- Reset mid-stream at t=2: state returns to IDLE with outputs 0. A new start replays the full sequence, proving buffers were retained.
- Boundary: wr_k=K is ignored. With K=1: sequence (x,0,y,0), (0,x',0,y'); busy lasts DRAIN+4 cycles.

Source files
------------

// File: rtl/mac_feeder_2x2_pkg.sv
// Shared definitions for the 2x2 MAC operand feeder: default width, FSM
// encoding and the skewed-lane validity rule.
package mac_feeder_2x2_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Lane 0 carries element t for t<k; lane 1 lags by one and carries t-1 for 1<=t<=k.
  function automatic logic lane_valid(input logic lane, input int unsigned t, input int unsigned k);
    logic v;
    if (lane == 1'b0) begin
      v = (t < k);
    end else begin
      v = (t >= 32'd1) && (t <= k);
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_feeder_2x2_operand_buf.sv
// 2xK operand register file: one write port, two combinational read ports
// (lane 0 at idx0, lane 1 at idx1). Contents are intentionally not reset.
module mac_feeder_2x2_operand_buf #(
  parameter int DW = 32,
  parameter int K  = 4,
  parameter int KW = 2
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic          wr_lane_i,
  input  logic [KW-1:0] wr_k_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [KW-1:0] rd0_idx_i,
  input  logic [KW-1:0] rd1_idx_i,
  output logic [DW-1:0] rd0_data_o,
  output logic [DW-1:0] rd1_data_o
);

  logic [DW-1:0] mem_q [2][K];

  // Element store; range and busy gating are done by the caller.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_lane_i][wr_k_i] <= wr_data_i;
    end
  end

  assign rd0_data_o = mem_q[0][rd0_idx_i];
  assign rd1_data_o = mem_q[1][rd1_idx_i];

endmodule

// File: rtl/mac_feeder_2x2.sv
// Operand feeder for the 2x2 MAC array: buffers A rows / B columns and
// streams them with a one-cycle skew on lane 1, framed by clear and done.
module mac_feeder_2x2
  import mac_feeder_2x2_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int K     = 4,
  parameter int DRAIN = 3,
  parameter int KW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic          wr_lane,
  input  logic [KW-1:0] wr_k,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mac_clr,
  output logic [DW-1:0] in_a0,
  output logic [DW-1:0] in_a1,
  output logic [DW-1:0] in_b0,
  output logic [DW-1:0] in_b1
);

  localparam int TW  = $clog2(K + 1);
  localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(K);
  localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);
  localparam logic [KW:0]    K_LIM  = (KW + 1)'(K);

  state_e         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           busy_q, busy_d, done_q, done_d, clr_q, clr_d;
  logic [DW-1:0]  a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;

  logic           wr_ok_s, v0_s, v1_s;
  logic [KW-1:0]  idx0_s, idx1_s;
  logic [DW-1:0]  a_rd0_s, a_rd1_s, b_rd0_s, b_rd1_s;

  assign wr_ok_s = wr_en && (state_q == ST_IDLE) && ({1'b0, wr_k} < K_LIM);
  // Reads follow the next count so the registered outputs show element t during cycle t.
  assign idx0_s  = KW'(t_d);
  assign idx1_s  = KW'(t_d - TW'(1));

  mac_feeder_2x2_operand_buf #(.DW(DW), .K(K), .KW(KW)) u_abuf (
    .clk_i      (clk),
    .wr_en_i    (wr_ok_s && !wr_sel),
    .wr_lane_i  (wr_lane),
    .wr_k_i     (wr_k),
    .wr_data_i  (wr_data),
    .rd0_idx_i  (idx0_s),
    .rd1_idx_i  (idx1_s),
    .rd0_data_o (a_rd0_s),
    .rd1_data_o (a_rd1_s)
  );

  mac_feeder_2x2_operand_buf #(.DW(DW), .K(K), .KW(KW)) u_bbuf (
    .clk_i      (clk),
    .wr_en_i    (wr_ok_s && wr_sel),
    .wr_lane_i  (wr_lane),
    .wr_k_i     (wr_k),
    .wr_data_i  (wr_data),
    .rd0_idx_i  (idx0_s),
    .rd1_idx_i  (idx1_s),
    .rd0_data_o (b_rd0_s),
    .rd1_data_o (b_rd1_s)
  );

  // Sequencer: IDLE -> CLEAR -> STREAM (t=0..K) -> DRAIN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          t_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STREAM;
        t_d     = '0;
      end
      ST_STREAM: begin
        if (t_q == T_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from the next state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    clr_d  = (state_d == ST_CLEAR);
    v0_s   = (state_d == ST_STREAM) && lane_valid(1'b0, 32'(t_d), K);
    v1_s   = (state_d == ST_STREAM) && lane_valid(1'b1, 32'(t_d), K);
    a0_d   = v0_s ? a_rd0_s : '0;
    b0_d   = v0_s ? b_rd0_s : '0;
    a1_d   = v1_s ? a_rd1_s : '0;
    b1_d   = v1_s ? b_rd1_s : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      dcnt_q  <= dcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mac_clr = clr_q;
  assign in_a0   = a0_q;
  assign in_a1   = a1_q;
  assign in_b0   = b0_q;
  assign in_b1   = b1_q;

endmodule

// File: tb/tb_mac_feeder_2x2.sv
// Directed bench for mac_feeder_2x2: K=4 instance checked every cycle against a
// queue-based model plus literal tables; a K=1 instance checked by table.
module tb_mac_feeder_2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  // K=4, DRAIN=3 instance
  logic        wr_en4 = 1'b0, wr_sel4 = 1'b0, wr_lane4 = 1'b0, start4 = 1'b0;
  logic [1:0]  wr_k4 = 2'd0;
  logic [31:0] wr_data4 = 32'd0;
  logic        busy4, done4, clr4;
  logic [31:0] a04, a14, b04, b14;

  // K=1, DRAIN=2 instance
  logic        wr_en1 = 1'b0, wr_sel1 = 1'b0, wr_lane1 = 1'b0, start1 = 1'b0;
  logic [0:0]  wr_k1 = 1'b0;
  logic [31:0] wr_data1 = 32'd0;
  logic        busy1, done1, clr1;
  logic [31:0] a01, a11, b01, b11;

  always #5 clk = ~clk;

  mac_feeder_2x2 #(.DW(32), .K(4), .DRAIN(3)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en4), .wr_sel(wr_sel4), .wr_lane(wr_lane4),
    .wr_k(wr_k4), .wr_data(wr_data4), .start(start4), .busy(busy4), .done(done4),
    .mac_clr(clr4), .in_a0(a04), .in_a1(a14), .in_b0(b04), .in_b1(b14)
  );

  mac_feeder_2x2 #(.DW(32), .K(1), .DRAIN(2)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_sel(wr_sel1), .wr_lane(wr_lane1),
    .wr_k(wr_k1), .wr_data(wr_data1), .start(start1), .busy(busy1), .done(done1),
    .mac_clr(clr1), .in_a0(a01), .in_a1(a11), .in_b0(b01), .in_b1(b11)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model of the K=4 instance ----------------
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        clr;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] b0;
    logic [31:0] b1;
  } rec_t;

  rec_t        mq[$];
  rec_t        cur = '0;
  logic [31:0] ma [2][4];
  logic [31:0] mb [2][4];

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] la [2][4];
    logic [31:0] lb [2][4];
    rec_t        r;
    if (!rst) begin
      mq.delete();
      cur <= '0;
    end else begin
      la = ma;
      lb = mb;
      if (!cur.busy) begin
        if (wr_en4) begin
          if (!wr_sel4) la[wr_lane4][wr_k4] = wr_data4;
          else          lb[wr_lane4][wr_k4] = wr_data4;
        end
        if (start4) begin
          r = '0; r.busy = 1'b1; r.clr = 1'b1;
          mq.push_back(r);
          for (int t = 0; t <= 4; t++) begin
            r = '0; r.busy = 1'b1;
            r.a0 = (t < 4)  ? la[0][t]   : 32'd0;
            r.b0 = (t < 4)  ? lb[0][t]   : 32'd0;
            r.a1 = (t >= 1) ? la[1][t-1] : 32'd0;
            r.b1 = (t >= 1) ? lb[1][t-1] : 32'd0;
            mq.push_back(r);
          end
          for (int d = 0; d < 3; d++) begin
            r = '0; r.busy = 1'b1;
            mq.push_back(r);
          end
          r = '0; r.busy = 1'b1; r.done = 1'b1;
          mq.push_back(r);
        end
      end
      ma <= la;
      mb <= lb;
      if (mq.size() > 0) cur <= mq.pop_front();
      else               cur <= '0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("cmp busy", {31'd0, busy4}, {31'd0, cur.busy});
      chk("cmp done", {31'd0, done4}, {31'd0, cur.done});
      chk("cmp clr",  {31'd0, clr4},  {31'd0, cur.clr});
      chk("cmp a0", a04, cur.a0);
      chk("cmp a1", a14, cur.a1);
      chk("cmp b0", b04, cur.b0);
      chk("cmp b1", b14, cur.b1);
    end
  end

  // ---------------- literal expectations for the K=4 run ----------------
  int e_clr [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int e_a0  [10] = '{0, 1, 2, 3, 4, 0, 0, 0, 0, 0};
  int e_a1  [10] = '{0, 0, 5, 6, 7, 8, 0, 0, 0, 0};
  int e_b0  [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int e_b1  [10] = '{0, 0, 2, 0, 1, 0, 0, 0, 0, 0};
  int e_dn  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic wr4(input logic sel, input logic lane, input logic [1:0] k, input logic [31:0] d);
    wr_en4 = 1'b1; wr_sel4 = sel; wr_lane4 = lane; wr_k4 = k; wr_data4 = d;
    @(negedge clk);
    wr_en4 = 1'b0;
  endtask

  task automatic wr1(input logic sel, input logic lane, input logic k, input logic [31:0] d);
    wr_en1 = 1'b1; wr_sel1 = sel; wr_lane1 = lane; wr_k1 = k; wr_data1 = d;
    @(negedge clk);
    wr_en1 = 1'b0;
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, " busy"}, {31'd0, busy4}, 32'd0);
    chk({tag, " done"}, {31'd0, done4}, 32'd0);
    chk({tag, " clr"},  {31'd0, clr4},  32'd0);
    chk({tag, " a0"}, a04, 32'd0);
    chk({tag, " a1"}, a14, 32'd0);
    chk({tag, " b0"}, b04, 32'd0);
    chk({tag, " b1"}, b14, 32'd0);
  endtask

  // One stream on the K=4 instance; optional co-write, lockout probe and mid-stream reset.
  task automatic run_seq(input bit co_wr, input int lock_at, input int rst_at);
    int busy_cnt;
    int ca0 [13];
    int ca1 [13];
    int cb0 [13];
    int cb1 [13];
    int o00, o01, o10, o11;
    busy_cnt = 0;
    if (co_wr) begin
      wr_en4 = 1'b1; wr_sel4 = 1'b1; wr_lane4 = 1'b1; wr_k4 = 2'd3; wr_data4 = 32'd0;
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wr_en4 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        chk($sformatf("tab busy[%0d]", c), {31'd0, busy4}, 32'd1);
        chk($sformatf("tab clr[%0d]", c),  {31'd0, clr4},  32'(e_clr[c]));
        chk($sformatf("tab done[%0d]", c), {31'd0, done4}, 32'(e_dn[c]));
        chk($sformatf("tab a0[%0d]", c), a04, 32'(e_a0[c]));
        chk($sformatf("tab a1[%0d]", c), a14, 32'(e_a1[c]));
        chk($sformatf("tab b0[%0d]", c), b04, 32'(e_b0[c]));
        chk($sformatf("tab b1[%0d]", c), b14, 32'(e_b1[c]));
      end else begin
        chk($sformatf("post busy[%0d]", c), {31'd0, busy4}, 32'd0);
        chk($sformatf("post done[%0d]", c), {31'd0, done4}, 32'd0);
      end
      busy_cnt += int'(busy4);
      ca0[c] = int'(a04); ca1[c] = int'(a14); cb0[c] = int'(b04); cb1[c] = int'(b14);
      if (c == lock_at) begin
        start4 = 1'b1; wr_en4 = 1'b1; wr_sel4 = 1'b0; wr_lane4 = 1'b0; wr_k4 = 2'd0; wr_data4 = 32'd99;
      end else begin
        start4 = 1'b0; wr_en4 = 1'b0;
      end
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1 chk_zero4("async rst");
        @(negedge clk);
        chk_zero4("held rst");
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    chk("busy length", 32'(busy_cnt), 32'd10);
    o00 = 0; o01 = 0; o10 = 0; o11 = 0;
    for (int c = 0; c < 13; c++) begin
      o00 += ca0[c] * cb0[c];
      o11 += ca1[c] * cb1[c];
      if (c < 12) begin
        o01 += ca0[c] * cb1[c+1];
        o10 += ca1[c+1] * cb0[c];
      end
    end
    chk("mac o00", 32'(o00), 32'd10);
    chk("mac o01", 32'(o01), 32'd5);
    chk("mac o10", 32'(o10), 32'd26);
    chk("mac o11", 32'(o11), 32'd17);
  endtask

  // K=1 expectations: (11,0,33,0), (0,22,0,44), two drain cycles, done.
  int k1_clr [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
  int k1_a0  [8] = '{0, 11, 0, 0, 0, 0, 0, 0};
  int k1_a1  [8] = '{0, 0, 22, 0, 0, 0, 0, 0};
  int k1_b0  [8] = '{0, 33, 0, 0, 0, 0, 0, 0};
  int k1_b1  [8] = '{0, 0, 44, 0, 0, 0, 0, 0};
  int k1_dn  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int k1_bz  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    int bc;
    repeat (2) @(negedge clk);
    chk_zero4("reset k4");
    chk("reset k1 busy", {31'd0, busy1}, 32'd0);
    chk("reset k1 done", {31'd0, done1}, 32'd0);
    chk("reset k1 clr",  {31'd0, clr1},  32'd0);
    chk("reset k1 a0", a01, 32'd0);
    chk("reset k1 b1", b11, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      wr4(1'b0, 1'b0, 2'(k), 32'(k + 1));
      wr4(1'b0, 1'b1, 2'(k), 32'(k + 5));
      wr4(1'b1, 1'b0, 2'(k), 32'd1);
    end
    wr4(1'b1, 1'b1, 2'd0, 32'd2);
    wr4(1'b1, 1'b1, 2'd1, 32'd0);
    wr4(1'b1, 1'b1, 2'd2, 32'd1);

    run_seq(1'b1, -1, -1);   // last B element written together with start
    run_seq(1'b0, 2, -1);    // restart and write attempt while streaming
    run_seq(1'b0, -1, -1);   // must be unchanged: a0 still starts at 1
    run_seq(1'b0, -1, 3);    // reset during STREAM t=2
    @(negedge clk);
    run_seq(1'b0, -1, -1);   // buffers retained across reset

    wr1(1'b0, 1'b0, 1'b0, 32'd11);
    wr1(1'b0, 1'b1, 1'b0, 32'd22);
    wr1(1'b1, 1'b0, 1'b0, 32'd33);
    wr1(1'b1, 1'b1, 1'b0, 32'd44);
    wr1(1'b0, 1'b0, 1'b1, 32'd77);   // wr_k == K: must be ignored
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bc = 0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("k1 busy[%0d]", c), {31'd0, busy1}, 32'(k1_bz[c]));
      chk($sformatf("k1 clr[%0d]", c),  {31'd0, clr1},  32'(k1_clr[c]));
      chk($sformatf("k1 done[%0d]", c), {31'd0, done1}, 32'(k1_dn[c]));
      chk($sformatf("k1 a0[%0d]", c), a01, 32'(k1_a0[c]));
      chk($sformatf("k1 a1[%0d]", c), a11, 32'(k1_a1[c]));
      chk($sformatf("k1 b0[%0d]", c), b01, 32'(k1_b0[c]));
      chk($sformatf("k1 b1[%0d]", c), b11, 32'(k1_b1[c]));
      bc += int'(busy1);
      @(negedge clk);
    end
    chk("k1 busy length", 32'(bc), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
